// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared state type and parameter check for the sr_latch command path
package sr_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} sr_ctrl_state_e;

   function automatic logic sr_params_ok(input int sync_stages, input int debounce_cycles,
                                         input int pulse_len, input int reset_priority);
      return (sync_stages >= 2) && (debounce_cycles >= 1) && (pulse_len >= 1) &&
             ((reset_priority == 0) || (reset_priority == 1));
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - synchroniser, debouncer and rising-edge detector for one raw command
module sr_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic req
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_x;
   logic                   deb_x;
   logic                   deb_q;
   logic [CNT_W-1:0]       cnt;

   assign sync_x = sync_chain[SYNC_STAGES-1];

   // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= '0;
         cnt        <= '0;
         deb_x      <= 1'b0;
         deb_q      <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
         deb_q      <= deb_x;
         if (sync_x == deb_x) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            deb_x <= ~deb_x;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign req = deb_x & ~deb_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// rtl/sr_cmd_conditioner.sv - turns raw set/reset commands into exclusive, guarded S/R pulses
module sr_cmd_conditioner
   import sr_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_LEN       = 2,
   parameter int RESET_PRIORITY  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_raw,
   input  logic rst_raw,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int PCNT_W = $clog2(PULSE_LEN + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_LEN - 1);

   if (!sr_params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, PULSE_LEN, RESET_PRIORITY)) begin : g_bad_params
      $error("sr_cmd_conditioner: parameter out of range");
   end

   sr_ctrl_state_e    state, state_d;
   logic [PCNT_W-1:0] pcnt, pcnt_d;
   logic              pend_s, pend_r, pend_s_d, pend_r_d;
   logic              req_s, req_r;
   logic              want_s, want_r;

   sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (set_raw),
      .req   (req_s)
   );

   sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (rst_raw),
      .req   (req_r)
   );

   assign want_s = req_s | pend_s;
   assign want_r = req_r | pend_r;

   always_comb begin
      state_d  = state;
      pcnt_d   = pcnt;
      pend_s_d = pend_s;
      pend_r_d = pend_r;
      conflict = 1'b0;
      case (state)
         IDLE: begin
            pcnt_d = '0;
            // Coinciding requests: one wins, the loser is dropped rather than queued.
            if (want_s && want_r) begin
               conflict = 1'b1;
               state_d  = (RESET_PRIORITY != 0) ? DRIVE_R : DRIVE_S;
               pend_s_d = 1'b0;
               pend_r_d = 1'b0;
            end else if (want_s) begin
               state_d  = DRIVE_S;
               pend_s_d = 1'b0;
            end else if (want_r) begin
               state_d  = DRIVE_R;
               pend_r_d = 1'b0;
            end
         end
         DRIVE_S, DRIVE_R: begin
            if (pcnt == PCNT_LAST) begin
               state_d = GAP;
               pcnt_d  = '0;
            end else begin
               pcnt_d = pcnt + PCNT_W'(1);
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state != IDLE) begin
         if (req_s) pend_s_d = 1'b1;
         if (req_r) pend_r_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pcnt   <= '0;
         pend_s <= 1'b0;
         pend_r <= 1'b0;
         S      <= 1'b0;
         R      <= 1'b0;
      end else begin
         state  <= state_d;
         pcnt   <= pcnt_d;
         pend_s <= pend_s_d;
         pend_r <= pend_r_d;
         S      <= (state_d == DRIVE_S);
         R      <= (state_d == DRIVE_R);
      end
   end

   assign busy = (state != IDLE);

   a_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(S && R));
   a_conflict_idle: assert property (@(posedge clk) disable iff (!rst_n) conflict |-> (state == IDLE));
   a_hold_s: assert property (@(posedge clk) disable iff (!rst_n) (S && (pcnt != PCNT_LAST)) |=> S);
   a_hold_r: assert property (@(posedge clk) disable iff (!rst_n) (R && (pcnt != PCNT_LAST)) |=> R);
   a_end_s: assert property (@(posedge clk) disable iff (!rst_n) (S && (pcnt == PCNT_LAST)) |=> (state == GAP));
   a_end_r: assert property (@(posedge clk) disable iff (!rst_n) (R && (pcnt == PCNT_LAST)) |=> (state == GAP));
   a_gap: assert property (@(posedge clk) disable iff (!rst_n) (state == GAP) |-> (!S && !R));

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb/tb_sr_cmd_conditioner.sv - scoreboard bench for sr_cmd_conditioner with default parameters
module tb_sr_cmd_conditioner;

   localparam int PULSE_LEN = 2;
   localparam int LAT       = 19;

   typedef struct {
      logic ch;
      int   start;
   } pulse_t;

   logic clk = 1'b0;
   logic rst_n;
   logic set_raw;
   logic rst_raw;
   logic S, R, busy, conflict;

   int     checks = 0;
   int     failures = 0;
   int     cyc = 0;
   pulse_t exp_q[$];
   logic   prev_s = 1'b0;
   logic   prev_r = 1'b0;
   int     start_s = 0;
   int     start_r = 0;
   int     overlap_cnt = 0;
   int     conflict_cnt = 0;
   int     conflict_cyc = -1;

   sr_cmd_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (16),
      .PULSE_LEN       (PULSE_LEN),
      .RESET_PRIORITY  (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_raw  (set_raw),
      .rst_raw  (rst_raw),
      .S        (S),
      .R        (R),
      .busy     (busy),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   task automatic expect_pulse(input logic ch, input int start);
      pulse_t p;
      p.ch    = ch;
      p.start = start;
      exp_q.push_back(p);
   endtask

   task automatic pulse_done(input logic ch, input int start, input int len);
      pulse_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_pulse: ch=%0d start=%0d len=%0d, required no pulse", ch, start, len);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (ch !== e.ch) begin
         failures++;
         $display("FAIL pulse_channel: got %0d required %0d", ch, e.ch);
      end
      checks++;
      if (start != e.start) begin
         failures++;
         $display("FAIL pulse_start ch=%0d: got cycle %0d required %0d", ch, start, e.start);
      end
      checks++;
      if (len != PULSE_LEN) begin
         failures++;
         $display("FAIL pulse_len ch=%0d: got %0d required %0d", ch, len, PULSE_LEN);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (S && R) overlap_cnt++;
      if (conflict) begin
         conflict_cnt++;
         conflict_cyc = cyc;
      end
      if ((S && !prev_s) || (R && !prev_r)) begin
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_with_pulse: got %b required 1 at cycle %0d", busy, cyc);
         end
      end
      if (S && !prev_s) start_s = cyc;
      if (R && !prev_r) start_r = cyc;
      if (!S && prev_s) pulse_done(1'b0, start_s, cyc - start_s);
      if (!R && prev_r) pulse_done(1'b1, start_r, cyc - start_r);
      prev_s = S;
      prev_r = R;
   endtask

   task automatic begin_test();
      overlap_cnt  = 0;
      conflict_cnt = 0;
      conflict_cyc = -1;
   endtask

   task automatic end_test(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s missing_pulses: got %0d outstanding required 0", name, exp_q.size());
      end
      exp_q.delete();
      checks++;
      if (overlap_cnt != 0) begin
         failures++;
         $display("FAIL %s s_and_r: got %0d overlap cycles required 0", name, overlap_cnt);
      end
      checks++;
      if ({S, R, busy} !== 3'b000) begin
         failures++;
         $display("FAIL %s idle_outputs: got S,R,busy=%b required 000", name, {S, R, busy});
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      set_raw = 1'b0;
      rst_raw = 1'b0;
      repeat (3) tick();
      checks++;
      if (S !== 1'b0) begin failures++; $display("FAIL reset_s: got %b required 0", S); end
      checks++;
      if (R !== 1'b0) begin failures++; $display("FAIL reset_r: got %b required 0", R); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict: got %b required 0", conflict); end
      rst_n = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_set_latency();
      int c0;
      begin_test();
      c0 = cyc;
      set_raw = 1'b1;
      expect_pulse(1'b0, c0 + LAT);
      repeat (30) tick();
      set_raw = 1'b0;
      repeat (25) tick();
      end_test("set_latency");
   endtask

   task automatic test_bounce();
      int c1;
      begin_test();
      for (int k = 0; k < 8; k++) begin
         rst_raw = (k % 2 == 0);
         repeat (5) tick();
      end
      c1 = cyc;
      rst_raw = 1'b1;
      expect_pulse(1'b1, c1 + LAT);
      repeat (30) tick();
      rst_raw = 1'b0;
      repeat (25) tick();
      end_test("bounce");
   endtask

   task automatic test_conflict();
      int c0;
      begin_test();
      c0 = cyc;
      set_raw = 1'b1;
      rst_raw = 1'b1;
      expect_pulse(1'b1, c0 + LAT);
      repeat (30) tick();
      set_raw = 1'b0;
      rst_raw = 1'b0;
      repeat (25) tick();
      checks++;
      if (conflict_cnt != 1) begin
         failures++;
         $display("FAIL conflict_count: got %0d required 1", conflict_cnt);
      end
      checks++;
      if (conflict_cyc != c0 + LAT - 1) begin
         failures++;
         $display("FAIL conflict_cycle: got %0d required %0d", conflict_cyc, c0 + LAT - 1);
      end
      end_test("conflict");
   endtask

   task automatic test_pending();
      int c0;
      begin_test();
      c0 = cyc;
      set_raw = 1'b1;
      expect_pulse(1'b0, c0 + LAT);
      repeat (3) tick();
      rst_raw = 1'b1;
      // reset request lands while the S pulse is in its guard cycle
      expect_pulse(1'b1, c0 + LAT + 4);
      repeat (40) tick();
      set_raw = 1'b0;
      rst_raw = 1'b0;
      repeat (25) tick();
      checks++;
      if (conflict_cnt != 0) begin
         failures++;
         $display("FAIL pending_conflict: got %0d required 0", conflict_cnt);
      end
      end_test("pending");
   endtask

   task automatic test_reset_mid_pulse();
      int c0;
      begin_test();
      c0 = cyc;
      set_raw = 1'b1;
      repeat (LAT + 1) tick();
      checks++;
      if (S !== 1'b1) begin
         failures++;
         $display("FAIL midpulse_precondition: got S=%b required 1 at cycle %0d", S, c0 + LAT + 1);
      end
      rst_n   = 1'b0;
      set_raw = 1'b0;
      #1;
      checks++;
      if (S !== 1'b0) begin failures++; $display("FAIL midpulse_s_cut: got %b required 0", S); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midpulse_busy: got %b required 0", busy); end
      prev_s = 1'b0;
      prev_r = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      end_test("reset_mid_pulse");
   endtask

   task automatic test_glitch();
      int c1;
      begin_test();
      set_raw = 1'b1;
      repeat (15) tick();
      set_raw = 1'b0;
      repeat (5) tick();
      c1 = cyc;
      set_raw = 1'b1;
      expect_pulse(1'b0, c1 + LAT);
      repeat (30) tick();
      set_raw = 1'b0;
      repeat (25) tick();
      end_test("glitch");
   endtask

   initial begin
      test_reset();
      test_set_latency();
      test_bounce();
      test_conflict();
      test_pending();
      test_reset_mid_pulse();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
